hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Sequencer for the MIPS multiply/divide resource and the HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the execute stage and runs an iterative shift-add multiplier or restoring divider over WIDTH cycles. While it runs, it holds `busy` so the pipeline can stall MFHI/MFLO and further mult/div issue. It sits beside the main ALU, receives operands from the same rs/rt bypass muxes, and owns the architectural HI/LO state.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request valid this cycle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- `rs_val`  in  WIDTH  dividend / multiplicand / MTHI-MTLO source.
- `rt_val`  in  WIDTH  divisor / multiplier.
- `flush`  in  1  abort the in-flight operation (exception/branch squash).
- `busy`  out  1  operation in progress; pipeline must stall MFHI/MFLO and mult/div issue.
- `done`  out  1  one-cycle pulse; HI/LO were updated by a mult/div this edge.
- `hi`  out  WIDTH  architectural HI.
- `lo`  out  WIDTH  architectural LO.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, `flush`=0:
  - MULT/MULTU/DIV/DIVU: latch operands. Signed ops latch magnitudes plus sign flags. Clear the iteration counter and go to RUN.
  - MTHI/MTLO: write `rs_val` to `hi`/`lo` at the next edge and stay in IDLE; `busy` stays 0 and `done` stays 0.
  - 110/111: ignored.
- RUN: one iteration per cycle.
  - Multiply: conditional add of the multiplicand into a 2·WIDTH accumulator, then shift right.
  - Divide: restoring shift-subtract into remainder/quotient.
  - After WIDTH iterations, go to FIX.
- FIX: apply sign correction and write HI/LO, assert `done`, return to IDLE.
  - MULT: negate the 2·WIDTH product if the operand signs differ; `hi` gets the upper half, `lo` the lower half.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - DIV/DIVU results: `lo`=quotient, `hi`=remainder.
- Divide by zero (DIV or DIVU): normal latency; `lo`=all ones, `hi`=`rs_val`.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- `start` while `busy`=1: ignored; no state change.
- `flush`=1 in any state: return to IDLE at the next edge, leave HI/LO unchanged, no `done`.
  - `flush` and `start` in the same cycle: `flush` wins.
- Arithmetic: operands are zero-extended (unsigned ops) or converted to magnitudes (signed ops). All internal datapaths are WIDTH+1 / 2·WIDTH bits, and no result is truncated except by the architected HI/LO split.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counter=0.
- Edge E0 accepts a mult/div. `busy`=1 from after E0 through the FIX cycle.
- Iterations occur at edges E1..E(WIDTH).
- FIX commits at edge E(WIDTH+1); `hi`/`lo` are valid and `done`=1 in the cycle after it, and `busy`=0 in that same cycle.
- Total occupancy is WIDTH+1 busy cycles (33 for WIDTH=32).
- A new `start` may be accepted in the same cycle that `done`=1.
- MTHI/MTLO: single-edge write, no `busy`.
- `rst` asserted mid-RUN clears all state immediately, asynchronously, and discards the operation.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU go IDLE→FIX directly using a combinational 2·WIDTH multiply.
  - `busy` is high for exactly 1 cycle and `done` follows one edge after acceptance.
  - Division is unchanged.
- Undefined: multiplication uses the iterative WIDTH+1-cycle path described above.

## Test plan
- Reset, then MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 33 busy cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulses once.
- MULT rs=0xFFFFFFFE (−2), rt=3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA; DIV rs=−7, rt=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU rs=100, rt=0 → `lo`=0xFFFFFFFF, `hi`=100; DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0x1234, then MTLO 0x5678 on consecutive cycles → `hi`=0x1234, `lo`=0x5678 with `busy` never asserted; a second `start` with MULTU mid-RUN → ignored, first result intact.
- `flush` at iteration 10 of DIVU → IDLE next edge, `hi`/`lo` keep prior values, no `done`; `rst` pulse mid-RUN → all outputs 0 immediately.
- With `MULDIV_FAST_MUL_EN`: MULTU 0x10000 × 0x10000 → `hi`=1, `lo`=0, one busy cycle; DIVU latency still 33.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Sequencer for the MIPS multiply/divide unit and the architectural HI/LO
// register pair. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from
// the execute stage. Multiplies and divides run as an iterative shift-add
// multiplier or restoring divider over WIDTH cycles. A final FIX cycle then
// applies sign correction and commits the result to HI/LO.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, MULT/MULTU use a combinational 2*WIDTH multiply and go
//   straight from IDLE to FIX, so busy is high for one cycle. Division is
//   unaffected. When undefined, multiplication is iterative.
//
// Ports:
//   i_clk     clock; all state changes on the rising edge
//   i_rst     asynchronous active-high reset
//   i_start   request valid this cycle
//   i_op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//             110/111 no-op
//   i_rs_val  multiplicand / dividend / MTHI-MTLO source
//   i_rt_val  multiplier / divisor
//   i_flush   abort the in-flight operation (exception / branch squash)
//   o_busy    mult/div in progress; pipeline stalls MFHI/MFLO and issue
//   o_done    one-cycle pulse; HI/LO were updated by a mult/div
//   o_hi      architectural HI
//   o_lo      architectural LO
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Conditional two's-complement negation, used both for taking operand
  // magnitudes and for the final sign correction.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v,
                                                 input logic               n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;   // result (product / quotient) negated
  logic                 r_neg_r;   // remainder takes dividend's sign
  logic                 r_dvz;     // divide by zero
  logic [WIDTH-1:0]     r_op_b;    // multiplicand or divisor magnitude
  // Upper WIDTH+1 bits: partial product / remainder.
  // Lower WIDTH bits: multiplier being consumed / dividend shifting out and
  // quotient shifting in.
  logic [2*WIDTH:0]     r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  // Operand decode. For mult/div ops, op[0]=0 selects the signed variant.
  logic                 w_signed;
  logic                 w_rs_neg;
  logic                 w_rt_neg;
  logic [WIDTH-1:0]     w_mag_rs;
  logic [WIDTH-1:0]     w_mag_rt;

  assign w_signed = ~i_op[2] & ~i_op[0];
  assign w_rs_neg = w_signed & i_rs_val[WIDTH-1];
  assign w_rt_neg = w_signed & i_rt_val[WIDTH-1];
  assign w_mag_rs = neg_if(i_rs_val, w_rs_neg);
  assign w_mag_rt = neg_if(i_rt_val, w_rt_neg);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_rs} * {{WIDTH{1'b0}}, w_mag_rt};
`endif

  // One iteration of either algorithm.
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_shift;
  logic                 w_div_ge;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH:0]     w_acc_step;

  always_comb begin
    // Multiply: add multiplicand into the upper part when the current
    // multiplier bit is set, then shift the whole accumulator right.
    w_mul_sum   = r_acc[2*WIDTH:WIDTH]
                + (r_acc[0] ? {1'b0, r_op_b} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder and subtract
    // the divisor if it fits (restoring).
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_op_b});
    w_div_diff  = w_div_shift - {1'b0, r_op_b};
    if (r_is_div) begin
      w_acc_step = {(w_div_ge ? w_div_diff : w_div_shift),
                    r_acc[WIDTH-2:0], w_div_ge};
    end else begin
      w_acc_step = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Sign correction for the commit in FIX.
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_prod_fix = neg2_if(r_acc[2*WIDTH-1:0], r_neg_q);
  // Division by zero yields an all-ones quotient regardless of sign; the
  // remainder is already the dividend magnitude, and re-applying the
  // dividend's sign returns rs_val unchanged.
  assign w_quo_fix  = r_dvz ? {WIDTH{1'b1}} : neg_if(r_acc[WIDTH-1:0], r_neg_q);
  assign w_rem_fix  = neg_if(r_acc[2*WIDTH-1:WIDTH], r_neg_r);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvz    <= 1'b0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_flush) begin
        // Squash wins over everything, including a same-cycle start.
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              if (!i_op[2]) begin
                r_is_div <= i_op[1];
                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                r_neg_r  <= w_rs_neg;
                r_dvz    <= i_op[1] & (i_rt_val == '0);
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                if (i_op[1]) begin
                  r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_rs};
                  r_op_b  <= w_mag_rt;
                  r_state <= RUN;
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                  r_acc   <= {1'b0, w_fast_prod};
                  r_op_b  <= w_mag_rs;
                  r_state <= FIX;
`else
                  r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_rt};
                  r_op_b  <= w_mag_rs;
                  r_state <= RUN;
`endif
                end
              end else if (i_op[1:0] == 2'b00) begin
                r_hi <= i_rs_val;
              end else if (i_op[1:0] == 2'b01) begin
                r_lo <= i_rs_val;
              end
            end
          end
          RUN: begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_ITER) begin
              r_state <= FIX;
            end
          end
          FIX: begin
            if (r_is_div) begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
//
// Directed self-checking bench for hilo_muldiv_ctrl (WIDTH=32). Expected
// values are hand-computed constants. Outputs are sampled on the falling
// clock edge. Expected multiply latency follows MULDIV_FAST_MUL_EN.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_N = 1;
`else
  localparam int MUL_N = 33;
`endif
  localparam int DIV_N = 33;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tot;
  int n_bad;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_rs_val (rs_val),
    .i_rt_val (rt_val),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Present a request for one rising edge; returns at the following
  // falling edge (first cycle after acceptance).
  task automatic launch(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Count busy cycles until busy drops (bounded), then check done and HI/LO.
  task automatic wait_done(input string tag, input int exp_n,
                           input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo);
    int  n;
    bit  early;
    n     = 0;
    early = 1'b0;
    while (busy && n < 200) begin
      if (done) early = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
    chk({tag, "_early_done"}, 64'(early), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    bit saw;
    n_tot  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 3'b111;
    rs_val = '0;
    rt_val = '0;
    flush  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Largest unsigned product, then single-cycle done pulse
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", MUL_N, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    chk("multu_done_pulse", 64'(done), 64'd0);

    // Each following launch lands in the done cycle of the previous op
    launch(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult_neg", MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);             // -7 / 2
    wait_done("div_neg_dvd", DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    launch(OP_DIVU, 32'd100, 32'd0);
    wait_done("divu_by0", DIV_N, 32'd100, 32'hFFFF_FFFF);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DIV_N, 32'h0000_0000, 32'h8000_0000);
    launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);             // 7 / -2
    wait_done("div_neg_dvs", DIV_N, 32'h0000_0001, 32'hFFFF_FFFD);
    launch(OP_DIV, 32'hFFFF_FF9C, 32'd0);             // -100 / 0
    wait_done("div_by0_neg", DIV_N, 32'hFFFF_FF9C, 32'hFFFF_FFFF);
    launch(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_done("divu_big", DIV_N, 32'h0000_000F, 32'h0FFF_FFFF);
    launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done("multu_2p32", MUL_N, 32'h0000_0001, 32'h0000_0000);

    // MTHI then MTLO on consecutive cycles, no busy
    start  = 1'b1;
    op     = OP_MTHI;
    rs_val = 32'h1234;
    @(negedge clk);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    op     = OP_MTLO;
    rs_val = 32'h5678;
    @(negedge clk);
    start  = 1'b0;
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);
    chk("mtlo_lo", 64'(lo), 64'h5678);
    chk("mtlo_hi", 64'(hi), 64'h1234);

    // flush with start in the same cycle: start dropped
    start  = 1'b1;
    op     = OP_MULTU;
    rs_val = 32'd3;
    rt_val = 32'd5;
    flush  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    flush  = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("flush_start_hilo", {32'(hi), 32'(lo)}, {32'h1234, 32'h5678});

    // start while busy is ignored
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    launch(OP_MULTU, 32'd7, 32'd9);
    wait_done("busy_ignore", DIV_N - 6, 32'd2, 32'd14);

    // flush at iteration 10 of DIVU
    launch(OP_DIVU, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    chk("flush_quiet", 64'(saw), 64'd0);
    chk("flush_hi", 64'(hi), 64'd2);
    chk("flush_lo", 64'(lo), 64'd14);

    // asynchronous reset mid-RUN
    launch(OP_DIVU, 32'd50, 32'd3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // recovery after reset
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_done("post_rst", MUL_N, 32'd0, 32'd42);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
